// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: one outstanding data-bus transaction per op,
// lane alignment of store data/mask and right-alignment of load data.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [1:0]  mem_size,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  input  logic        flush,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_wen,
  output logic [63:0] req_addr,
  output logic [63:0] req_wdata,
  output logic [7:0]  req_wmask,
  input  logic        resp_valid,
  input  logic [63:0] resp_rdata,
  output logic [63:0] mem_data,
  output logic [7:0]  byte_enable,
  output logic        done,
  output logic        misalign,
  output logic        stall_req
);
  localparam int REG_BUS = 64;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e               state_q, state_d;
  logic                 killed_q, killed_d;
  logic                 wen_q, wen_d;
  logic [REG_BUS-1:0]   addr_q, addr_d;
  logic [REG_BUS-1:0]   wdata_q, wdata_d;
  logic [REG_BUS-1:0]   mem_data_q, mem_data_d;
  logic [7:0]           be_q, be_d;
  logic                 misalign_q, misalign_d;
  logic                 op, mis;
  logic [7:0]           be_new;

  always_comb begin
    op = ex_valid & (mem_ren | mem_wen);
    mis = 1'b0;
    be_new = 8'h01;
    case (mem_size)
      2'd0: begin mis = 1'b0;             be_new = 8'h01; end
      2'd1: begin mis = mem_addr[0];      be_new = 8'h03; end
      2'd2: begin mis = |mem_addr[1:0];   be_new = 8'h0F; end
      default: begin mis = |mem_addr[2:0]; be_new = 8'hFF; end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    killed_d   = killed_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_data_d = mem_data_q;
    be_d       = be_q;
    // A flushed instruction raises no exception.
    misalign_d = (state_q == S_IDLE) & op & mis & ~flush;
    case (state_q)
      S_IDLE: begin
        if (op && !mis && !flush) begin
          state_d  = S_REQ;
          killed_d = 1'b0;
          wen_d    = mem_wen;
          addr_d   = mem_addr;
          wdata_d  = mem_wdata;
          be_d     = be_new;
        end
      end
      S_REQ: begin
        if (req_ready) begin
          state_d  = S_WAIT;
          killed_d = flush;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (flush) killed_d = 1'b1;
        // The response cannot be cancelled; a killed op just drops it.
        if (resp_valid) begin
          killed_d = 1'b0;
          if (killed_q || flush) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            if (!wen_q) mem_data_d = resp_rdata >> {addr_q[2:0], 3'b000};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      killed_q   <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_data_q <= '0;
      be_q       <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      killed_q   <= killed_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_data_q <= mem_data_d;
      be_q       <= be_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    req_valid   = (state_q == S_REQ);
    req_wen     = wen_q;
    req_addr    = {addr_q[63:3], 3'b000};
    req_wdata   = wdata_q << {addr_q[2:0], 3'b000};
    req_wmask   = wen_q ? (be_q << addr_q[2:0]) : 8'h00;
    mem_data    = mem_data_q;
    byte_enable = be_q;
    done        = (state_q == S_DONE);
    misalign    = misalign_q;
    stall_req   = (state_q == S_REQ) || (state_q == S_WAIT) ||
                  ((state_q == S_IDLE) && op && !mis && !flush);
  end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-stage load/store unit for the 64-bit RISC-V core. It sits between the execute-stage outputs and the write-back mux. It turns a decoded load or store into a single data-bus transaction with a valid/ready request and a response. It right-aligns returned load data and produces the `mem_data` / `byte_enable` pair that write-back uses for extension. It stalls the pipeline while a transaction is outstanding.

## Interface
- No parameters. Data width is `REG_BUS` (64 bits); the bus is 64-bit, 8-byte aligned.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `ex_valid` in 1: the execute-stage instruction is valid.
- `mem_ren` in 1: the instruction is a load.
- `mem_wen` in 1: the instruction is a store. `mem_ren` and `mem_wen` are never both 1.
- `mem_size` in 2: access size; 0=byte, 1=half, 2=word, 3=dword.
- `mem_addr` in 64: effective address, taken from the ALU result.
- `mem_wdata` in 64: store data, right-aligned.
- `flush` in 1: the pipeline kills the current instruction.
- `req_valid` out 1: a bus request is presented.
- `req_ready` in 1: the bus accepts the request. The handshake completes on a cycle where `req_valid` and `req_ready` are both 1.
- `req_wen` out 1: 1 for a write, 0 for a read.
- `req_addr` out 64: `{mem_addr[63:3], 3'b000}`.
- `req_wdata` out 64: `mem_wdata << (8*mem_addr[2:0])`.
- `req_wmask` out 8: `byte_enable << mem_addr[2:0]`; 0 for reads.
- `resp_valid` in 1: response pulse, one cycle per accepted request.
- `resp_rdata` in 64: raw 8-byte-aligned read data.
- `mem_data` out 64: `resp_rdata >> (8*addr[2:0])`, registered.
- `byte_enable` out 8: size encoding for write-back; 0x01, 0x03, 0x0F or 0xFF for byte, half, word, dword.
- `done` out 1: one-cycle pulse; `mem_data` / `byte_enable` are valid for write-back.
- `misalign` out 1: one-cycle pulse flagging a misaligned access.
- `stall_req` out 1: holds the front of the pipeline.

## Operation
- The FSM has four states: IDLE, REQ, WAIT, DONE.
- An op is `ex_valid & (mem_ren | mem_wen)`.
- Misalignment check:
  - half: `addr[0]` set.
  - word: `addr[1:0]` nonzero.
  - dword: `addr[2:0]` nonzero.
  - byte: never misaligned.
- IDLE, on an aligned op with `flush` low:
  - capture addr, size, wen and wdata;
  - compute `byte_enable`;
  - go to REQ.
- IDLE, on a misaligned op: pulse `misalign`, issue no bus request, stay in IDLE.
- REQ:
  - `req_valid`=1, with all `req_*` fields driven from the captured values and held stable until the handshake.
  - On the handshake, go to WAIT.
  - If `flush` is high and no handshake occurs in that cycle, go to IDLE; nothing is issued.
- WAIT: on `resp_valid`, latch `mem_data` (reads only; stores leave it unchanged) and go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Flush after the handshake:
  - set an internal `killed` flag;
  - still wait for `resp_valid`, because a response cannot be cancelled;
  - on the response, go to IDLE directly and suppress `done`.
- `stall_req`:
  - 1 in REQ and WAIT;
  - 1 in IDLE when an aligned op is present and `flush`=0;
  - 0 in DONE and for misaligned or flushed ops.
- Ops with `ex_valid`=1 in REQ or WAIT belong to the stalled instruction and are not recaptured.
- `resp_valid` outside WAIT is ignored.
- Reset values: all outputs 0, state IDLE, `killed`=0, `mem_data`=0, `byte_enable`=0.
- Reset mid-transaction returns to IDLE immediately; any late response is then ignored.

## Timing
- Cycle 0: IDLE captures the op; `stall_req`=1 combinationally.
- Cycle 1: earliest `req_valid`.
- Cycle 2: earliest `resp_valid` (the cycle after the handshake, at the earliest).
- Cycle 3: `done` with registered `mem_data`; `stall_req`=0; the pipeline advances.
- Minimum latency is therefore 3 cycles (captured op to `done`), plus any `req_ready` wait and response wait.
- Throughput is at most one transaction per 4 cycles; one outstanding request.
- `misalign` is registered: it pulses the cycle after the misaligned op is presented in IDLE.

## Test plan
- Byte load:
  - stimulus: addr=0x8000_0005, size 0, `req_ready`=1, response one cycle later with rdata=0x1122_3344_5566_7788;
  - response: `req_addr`=0x8000_0000, `mem_data[7:0]`=0x33, `byte_enable`=0x01, `done` at cycle 3.
- Word store:
  - stimulus: addr=0x...4, wdata=0xDEADBEEF;
  - response: `req_wdata`=0xDEADBEEF_00000000, `req_wmask`=0xF0, `req_wen`=1, `done` pulses.
- Backpressure:
  - stimulus: `req_ready`=0 for 5 cycles;
  - response: `req_valid` and all fields stable, `stall_req` high throughout, handshake on the 6th cycle.
- Misaligned accesses:
  - half at addr 0x...3: `misalign` pulse, no `req_valid`, `stall_req`=0;
  - dword at addr 0x...4: same behaviour.
- Flush:
  - in REQ before `req_ready`: IDLE next cycle, no `done`;
  - in WAIT: the response is consumed, no `done`, then IDLE.
- Reset:
  - stimulus: `rst`=0 while in WAIT;
  - response: IDLE, all outputs 0; a stray `resp_valid` afterwards gives no `done`.
